// File: rtl/ic1337_pkg.sv
// Shared types and constants for the ic1337 arbiter slice.
package ic1337_pkg;

  localparam int VEC_W = 3;
  localparam int RSP_W = 3;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2
  } state_e;

endpackage

// File: rtl/ic1337_arbiter_if.sv
// Requester handshake plus ic1337 pin bundle for the arbiter.
// The slave modport is the arbiter's view; master is the requester/chip side.
interface ic1337_arbiter_if;
  import ic1337_pkg::*;

  logic             req0;
  logic [VEC_W-1:0] in0;
  logic             req1;
  logic [VEC_W-1:0] in1;
  logic             gnt0;
  logic             gnt1;
  logic             I0;
  logic             I1;
  logic             I2;
  logic             Q0;
  logic             Q1;
  logic             Z;
  logic             rsp_valid;
  logic             rsp_id;
  logic [RSP_W-1:0] rsp_data;
  logic             busy;

  modport slave (
    input  req0, in0, req1, in1, Q0, Q1, Z,
    output gnt0, gnt1, I0, I1, I2, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req0, in0, req1, in1, Q0, Q1, Z,
    input  gnt0, gnt1, I0, I1, I2, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/ic1337_rr_pick.sv
// Two-way winner select, purely combinational.
// Build option IC1337_ARB_FIXED_PRIO_EN: req0 always wins a tie and the
// pointer input disappears; otherwise the requester not granted last wins.
module ic1337_rr_pick
  import ic1337_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifndef IC1337_ARB_FIXED_PRIO_EN
  input  logic ptr,
`endif
  output logic win
);

  // Winner id; only meaningful when at least one request is high.
  always_comb begin
    win = ID_REQ0;
`ifdef IC1337_ARB_FIXED_PRIO_EN
    if (!req0 && req1) win = ID_REQ1;
`else
    if (req0 && req1) win = ~ptr;
    else if (req1)    win = ID_REQ1;
`endif
  end

endmodule

// File: rtl/ic1337_arbiter.sv
// Round-robin share of one ic1337 flip-flop unit between two requesters.
// Grants a winner, holds its vector on I0..I2 for HOLD_CYCLES edges, then
// captures {Z,Q1,Q0} and returns it tagged with the winner's id.
// Build option IC1337_ARB_FIXED_PRIO_EN: fixed priority, no pointer register.
module ic1337_arbiter
  import ic1337_pkg::*;
#(
  parameter int               HOLD_CYCLES = 2,
  parameter logic [VEC_W-1:0] IDLE_VEC    = 3'b000
) (
  input  logic clk,
  input  logic rst_n,
  ic1337_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [RSP_W-1:0] rsp_data_q, rsp_data_d;
  logic             busy_q;
  logic             win;
  logic             any_req;

`ifndef IC1337_ARB_FIXED_PRIO_EN
  logic ptr_q, ptr_d;
`endif

  assign any_req = bus.req0 | bus.req1;

  ic1337_rr_pick u_pick (
    .req0 (bus.req0),
    .req1 (bus.req1),
`ifndef IC1337_ARB_FIXED_PRIO_EN
    .ptr  (ptr_q),
`endif
    .win  (win)
  );

  // Next-state and next-output logic for the IDLE/DRIVE/SAMPLE sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    vec_d       = vec_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
`ifndef IC1337_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = win;
          vec_d   = (win == ID_REQ1) ? bus.in1 : bus.in0;
          gnt0_d  = (win == ID_REQ0);
          gnt1_d  = (win == ID_REQ1);
`ifndef IC1337_ARB_FIXED_PRIO_EN
          ptr_d   = win;
`endif
          cnt_d   = 4'(HOLD_CYCLES - 1);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == 4'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SAMPLE: begin
        rsp_data_d  = {bus.Z, bus.Q1, bus.Q0};
        rsp_id_d    = owner_q;
        rsp_valid_d = 1'b1;
        vec_d       = IDLE_VEC;
        state_d     = IDLE;
      end
      default: begin
        vec_d   = IDLE_VEC;
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, capture and registered outputs; reset drops any transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= ID_REQ0;
      vec_q       <= IDLE_VEC;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      vec_q       <= vec_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= (state_d != IDLE);
    end
  end

`ifndef IC1337_ARB_FIXED_PRIO_EN
  // Last-grant pointer; starts at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= ID_REQ1;
    else        ptr_q <= ptr_d;
  end
`endif

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.I0        = vec_q[0];
  assign bus.I1        = vec_q[1];
  assign bus.I2        = vec_q[2];
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ic1337_arbiter.sv
// Directed bench for ic1337_arbiter: one HOLD_CYCLES=2 instance and one
// HOLD_CYCLES=1 instance sharing clock and reset.
module tb_ic1337_arbiter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  ic1337_arbiter_if if0 ();
  ic1337_arbiter_if if1 ();

  ic1337_arbiter #(.HOLD_CYCLES(2), .IDLE_VEC(3'b000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  ic1337_arbiter #(.HOLD_CYCLES(1), .IDLE_VEC(3'b000)) dut_h1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ipins0();
    return {if0.I2, if0.I1, if0.I0};
  endfunction

  initial begin
    int  edge_cnt;
    int  last_edge;
    bit  found;
    bit  both_hi;
    bit  overlap;
    bit  stray_rsp;
    bit  last_id;
    bit  exp_id;

    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    if0.req0 = 0; if0.req1 = 0; if0.in0 = '0; if0.in1 = '0;
    if0.Q0 = 0; if0.Q1 = 0; if0.Z = 0;
    if1.req0 = 0; if1.req1 = 0; if1.in0 = '0; if1.in1 = '0;
    if1.Q0 = 0; if1.Q1 = 0; if1.Z = 0;

    tick();
    tick();
    check_eq("rst_gnt0", if0.gnt0, 0);
    check_eq("rst_gnt1", if0.gnt1, 0);
    check_eq("rst_rsp_valid", if0.rsp_valid, 0);
    check_eq("rst_rsp_id", if0.rsp_id, 0);
    check_eq("rst_rsp_data", if0.rsp_data, 0);
    check_eq("rst_busy", if0.busy, 0);
    check_eq("rst_ipins", ipins0(), 3'b000);

    rst_n = 1'b1;
    tick();
    check_eq("idle_busy", if0.busy, 0);

    // Single request from requester 0, vector 101, response 110.
    if0.req0 = 1; if0.in0 = 3'b101;
    tick();
    check_eq("t1_gnt0", if0.gnt0, 1);
    check_eq("t1_gnt1", if0.gnt1, 0);
    check_eq("t1_busy", if0.busy, 1);
    check_eq("t1_ipins_e1", ipins0(), 3'b101);
    if0.req0 = 0; if0.in0 = 3'b010;
    tick();
    check_eq("t1_gnt0_pulse", if0.gnt0, 0);
    check_eq("t1_ipins_e2", ipins0(), 3'b101);
    tick();
    check_eq("t1_ipins_e3", ipins0(), 3'b101);
    check_eq("t1_no_early_rsp", if0.rsp_valid, 0);
    if0.Z = 1; if0.Q1 = 1; if0.Q0 = 0;
    tick();
    check_eq("t1_rsp_valid", if0.rsp_valid, 1);
    check_eq("t1_rsp_id", if0.rsp_id, 0);
    check_eq("t1_rsp_data", if0.rsp_data, 3'b110);
    check_eq("t1_ipins_idle", ipins0(), 3'b000);
    check_eq("t1_busy_done", if0.busy, 0);
    tick();
    check_eq("t1_rsp_pulse", if0.rsp_valid, 0);

    // Reset in the middle of a DRIVE phase.
    if0.req1 = 1; if0.in1 = 3'b111;
    tick();
    check_eq("rs_gnt1", if0.gnt1, 1);
    if0.req1 = 0;
    rst_n = 1'b0;
    tick();
    check_eq("rs_busy", if0.busy, 0);
    check_eq("rs_gnt1_clr", if0.gnt1, 0);
    check_eq("rs_ipins", ipins0(), 3'b000);
    check_eq("rs_rsp_valid", if0.rsp_valid, 0);
    rst_n = 1'b1;
    stray_rsp = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (if0.rsp_valid) stray_rsp = 1;
    end
    check_eq("rs_no_rsp", stray_rsp, 0);

    // Both requesters held high continuously.
    if0.req0 = 1; if0.in0 = 3'b001;
    if0.req1 = 1; if0.in1 = 3'b100;
    if0.Z = 0; if0.Q1 = 1; if0.Q0 = 1;
    edge_cnt = 0; last_edge = 0; both_hi = 0; overlap = 0; last_id = 0;
    for (int g = 0; g < 4; g++) begin
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
        tick();
        edge_cnt++;
        if (if0.gnt0 && if0.gnt1) both_hi = 1;
        if (if0.rsp_valid && (if0.gnt0 || if0.gnt1)) overlap = 1;
        if (if0.rsp_valid) begin
          check_eq("tie_rsp_id", if0.rsp_id, last_id);
          check_eq("tie_rsp_data", if0.rsp_data, 3'b011);
        end
        if (if0.gnt0 || if0.gnt1) begin
          found = 1;
`ifdef IC1337_ARB_FIXED_PRIO_EN
          exp_id = 0;
`else
          exp_id = (g % 2 == 1);
`endif
          check_eq("tie_winner", if0.gnt1, exp_id);
          check_eq("tie_ipins", ipins0(), exp_id ? 3'b100 : 3'b001);
          if (g > 0) check_eq("tie_gap", 8'(edge_cnt - last_edge), 8'd4);
          last_edge = edge_cnt;
          last_id = if0.gnt1;
        end
      end
      if (!found) begin
        check_eq("tie_timeout", 0, 1);
        break;
      end
    end
    check_eq("tie_gnt_excl", both_hi, 0);
    check_eq("tie_rsp_gnt_excl", overlap, 0);
    if0.req0 = 0; if0.req1 = 0;
    for (int c = 0; c < 6; c++) tick();
    check_eq("tie_drain_busy", if0.busy, 0);

    // HOLD_CYCLES = 1 instance, requester 1, vector 011.
    if1.req1 = 1; if1.in1 = 3'b011;
    tick();
    check_eq("h1_gnt1", if1.gnt1, 1);
    check_eq("h1_ipins", {if1.I2, if1.I1, if1.I0}, 3'b011);
    if1.req1 = 0;
    tick();
    check_eq("h1_no_early_rsp", if1.rsp_valid, 0);
    if1.Z = 1; if1.Q1 = 0; if1.Q0 = 1;
    tick();
    check_eq("h1_rsp_valid", if1.rsp_valid, 1);
    check_eq("h1_rsp_id", if1.rsp_id, 1);
    check_eq("h1_rsp_data", if1.rsp_data, 3'b101);
    check_eq("h1_busy", if1.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
